// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the RV32 instruction/data memory arbiter.
package rv32_mem_pkg;

    localparam int MEMORY_SIZE          = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Which port owns the response currently leaving the memory.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_INSTR = 2'd1,
        RSP_DATA  = 2'd2
    } rsp_src_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Core-side request/response and memory-side bus of the arbiter.
interface rv32_mem_arbiter_if #(
    parameter int AW = $clog2(rv32_mem_pkg::MEMORY_SIZE)
);
    logic          ireq_i;
    logic [31:0]   iaddr_i;
    logic          igrant_o;
    logic          ivalid_o;
    logic [31:0]   idata_o;
    logic          dreq_i;
    logic          dwe_i;
    logic [31:0]   daddr_i;
    logic [31:0]   dwdata_i;
    logic          dgrant_o;
    logic          dvalid_o;
    logic [31:0]   drdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          err_o;
    logic [31:0]   fault_addr_o;

    // Environment side: the core requests plus the memory read data.
    modport master (
        output ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i, mem_rdata_i,
        input  igrant_o, ivalid_o, idata_o, dgrant_o, dvalid_o, drdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, fault_addr_o
    );

    modport slave (
        input  ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i, mem_rdata_i,
        output igrant_o, ivalid_o, idata_o, dgrant_o, dvalid_o, drdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, fault_addr_o
    );
endinterface

// File: rtl/rv32_mem_addr_check.sv
// Byte-address legality check (word aligned, inside memory) and word index.
module rv32_mem_addr_check #(
    parameter int MEM_SIZE = rv32_mem_pkg::MEMORY_SIZE,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic [31:0]   addr,
    output logic          legal,
    output logic [AW-1:0] word_idx
);
    // One extra bit so the byte limit cannot overflow for a full 4 GiB space.
    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_SIZE) << 2;

    assign legal    = (addr[1:0] == 2'b00) && ({1'b0, addr} < BYTE_LIMIT);
    assign word_idx = addr[AW+1:2];

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates fetch and load/store onto one synchronous-read memory, data first with a fetch starvation guard.
module rv32_mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int MEM_SIZE     = MEMORY_SIZE,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int AW           = $clog2(MEM_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    rv32_mem_arbiter_if.slave bus
);
    localparam int CW     = $clog2(STARVE_LIMIT + 1);
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    logic [31:0]   port_addr [2];
    logic [1:0]    port_legal;
    logic [AW-1:0] port_idx  [2];

    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
    rsp_src_e      rsp_src_reg, rsp_src_next;
    logic          rsp_err_reg, rsp_err_next;
    logic          rsp_store_reg, rsp_store_next;
    logic [31:0]   fault_addr_reg, fault_addr_next;

    logic          igrant;
    logic          dgrant;
    mem_req_t      sel_req;
    logic          sel_legal;
    logic [AW-1:0] sel_idx;

    assign port_addr[PORT_I] = bus.iaddr_i;
    assign port_addr[PORT_D] = bus.daddr_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chk
            rv32_mem_addr_check #(
                .MEM_SIZE (MEM_SIZE),
                .AW       (AW)
            ) u_chk (
                .addr     (port_addr[gi]),
                .legal    (port_legal[gi]),
                .word_idx (port_idx[gi])
            );
        end
    endgenerate

    // Fetch wins when alone or once it has been passed over STARVE_LIMIT times.
    always_comb begin
        igrant = 1'b0;
        dgrant = 1'b0;
        if (rst_i) begin
            if (bus.ireq_i && (!bus.dreq_i || starve_cnt_reg >= CW'(STARVE_LIMIT))) begin
                igrant = 1'b1;
            end else if (bus.dreq_i) begin
                dgrant = 1'b1;
            end
        end
    end

    always_comb begin
        sel_req   = '0;
        sel_legal = 1'b0;
        sel_idx   = '0;
        if (igrant) begin
            sel_req.addr = bus.iaddr_i;
            sel_legal    = port_legal[PORT_I];
            sel_idx      = port_idx[PORT_I];
        end else if (dgrant) begin
            sel_req.we    = bus.dwe_i;
            sel_req.addr  = bus.daddr_i;
            sel_req.wdata = bus.dwdata_i;
            sel_legal     = port_legal[PORT_D];
            sel_idx       = port_idx[PORT_D];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            starve_cnt_reg <= '0;
            rsp_src_reg    <= RSP_NONE;
            rsp_err_reg    <= 1'b0;
            rsp_store_reg  <= 1'b0;
            fault_addr_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rsp_src_reg    <= rsp_src_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_store_reg  <= rsp_store_next;
            fault_addr_reg <= fault_addr_next;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.ireq_i || igrant) begin
            starve_cnt_next = '0;
        end else if (dgrant && starve_cnt_reg < CW'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end

        rsp_src_next = RSP_NONE;
        if (igrant) begin
            rsp_src_next = RSP_INSTR;
        end else if (dgrant) begin
            rsp_src_next = RSP_DATA;
        end

        rsp_err_next   = (igrant || dgrant) && !sel_legal;
        rsp_store_next = sel_req.we;

        // Captured at grant so it is visible alongside err_o in the response cycle.
        fault_addr_next = fault_addr_reg;
        if (rsp_err_next) begin
            fault_addr_next = sel_req.addr;
        end
    end

    always_comb begin
        bus.igrant_o     = igrant;
        bus.dgrant_o     = dgrant;
        bus.mem_en_o     = sel_legal;
        bus.mem_we_o     = sel_legal && sel_req.we;
        bus.mem_addr_o   = sel_legal ? sel_idx : '0;
        bus.mem_wdata_o  = sel_req.wdata;
        bus.ivalid_o     = 1'b0;
        bus.idata_o      = '0;
        bus.dvalid_o     = 1'b0;
        bus.drdata_o     = '0;
        bus.err_o        = 1'b0;
        bus.fault_addr_o = fault_addr_reg;

        // Gating with rst_i kills a response whose grant preceded reset.
        if (rst_i) begin
            case (rsp_src_reg)
                RSP_INSTR: begin
                    bus.ivalid_o = 1'b1;
                    bus.idata_o  = rsp_err_reg ? 32'd0 : bus.mem_rdata_i;
                    bus.err_o    = rsp_err_reg;
                end
                RSP_DATA: begin
                    bus.dvalid_o = 1'b1;
                    bus.drdata_o = (rsp_err_reg || rsp_store_reg) ? 32'd0 : bus.mem_rdata_i;
                    bus.err_o    = rsp_err_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-port, synchronous-read word memory between the RV32 core's instruction-fetch port and its load/store data port.
- Accepts at most one access per cycle and picks a winner: data first, with a starvation guard for fetch.
- Range- and alignment-checks every address and returns read data or an error one cycle after grant.
- Sits between the RV32 core and the unified program/data memory used in simulation and synthesis.

Parameters:
MEM_SIZE, 32, memory depth in 32-bit words (byte space 0 .. MEM_SIZE*4-1)
STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win
AW, $clog2(MEM_SIZE), word-index width on the memory side

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
ireq_i  in  1  fetch request; held with iaddr_i until igrant_o
iaddr_i  in  32  fetch byte address
igrant_o  out  1  fetch accepted this cycle
ivalid_o  out  1  fetch response valid, one cycle after igrant_o
idata_o  out  32  fetched word
dreq_i  in  1  data request; held with daddr_i, dwe_i and dwdata_i until dgrant_o
dwe_i  in  1  1 = store, 0 = load
daddr_i  in  32  data byte address
dwdata_i  in  32  store data
dgrant_o  out  1  data access accepted this cycle
dvalid_o  out  1  data response valid (load data or store ack), one cycle after dgrant_o
drdata_o  out  32  load data; 0 for a store ack
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  word index (byte address >> 2)
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data, valid the cycle after mem_en_o
err_o  out  1  one-cycle pulse with an erroring response
fault_addr_o  out  32  byte address of the last erroring access

Behaviour:
- Reset: rst_i sampled low at a clock edge → on that edge all registered outputs go to 0, starvation counter = 0, response stage = RSP_NONE, fault_addr_o = 0.
- Grants and mem_* outputs are combinational from requests and state; they are forced to 0 in any cycle where rst_i is low.
- Arbitration (per cycle):
  - dreq_i only → data wins.
  - ireq_i only → fetch wins.
  - Both, starve_cnt < STARVE_LIMIT → data wins; starve_cnt += 1.
  - Both, starve_cnt == STARVE_LIMIT → fetch wins.
  - starve_cnt clears whenever fetch is granted or ireq_i is low; it saturates, never wraps.
- Grant cycle: exactly one of igrant_o/dgrant_o = 1.
  - Address legal → mem_en_o = 1, mem_addr_o = addr[AW+1:2], mem_we_o = dwe_i for data and 0 for fetch, mem_wdata_o = dwdata_i.
  - Address legal means addr[1:0] == 0 and addr < MEM_SIZE*4.
- Illegal address: grant still given; mem_en_o = 0 and mem_we_o = 0.
- Response stage states: RSP_NONE, RSP_INSTR, RSP_DATA; the register is loaded every cycle from the grant decision.
  - RSP_INSTR → ivalid_o = 1, idata_o = mem_rdata_i (or 0 if erroring).
  - RSP_DATA → dvalid_o = 1, drdata_o = mem_rdata_i for a legal load, 0 for a store or error.
  - Any erroring response → err_o = 1 and fault_addr_o ← faulting address; fault_addr_o holds until the next error.
- Throughput: back-to-back grants every cycle; latency grant → valid = 1 cycle, fixed.
- Outputs with no response in progress: ivalid_o/dvalid_o = 0; idata_o/drdata_o = 0.
- Reset mid-operation: a grant issued the cycle before rst_i low produces no valid pulse.
- Store then load to the same address in consecutive grants → the load returns the new data (memory write-first is a memory requirement).
- Requests dropped before grant are legal and leave no state behind, except that starve_cnt clears.

Decomposition:
- Package rv32_mem_pkg: MEMORY_SIZE, rsp_src_e enum {RSP_NONE, RSP_INSTR, RSP_DATA}, mem_req_t struct {we, addr, wdata}, default STARVE_LIMIT.
- Testbench constants stay in tb_constants.
- One sub-module: rv32_mem_addr_check. Combinational; inputs addr and MEM_SIZE; outputs legal and word index. Instantiated once per port.

Test Plan:
- Memory word 0 = 0x04002083; ireq_i=1, iaddr_i=0x0 → igrant_o in cycle 0; cycle 1: ivalid_o=1, idata_o=0x04002083, err_o=0.
- mem[16]=0x00000003; ireq_i (iaddr_i=0x4) and dreq_i (load 0x40) both held from cycle 0 →
  - cycle 0: dgrant_o, mem_addr_o=16.
  - cycle 1: dvalid_o, drdata_o=0x3, and igrant_o.
  - cycle 2: ivalid_o with mem[1].
- Store dwe_i=1, daddr_i=0x40, dwdata_i=0x3F → mem_we_o=1, mem_addr_o=16; next cycle dvalid_o=1, drdata_o=0. A following load of 0x40 → drdata_o=0x3F.
- ireq_i and dreq_i held continuously, STARVE_LIMIT=4 → dgrant_o in cycles 0-3, igrant_o in cycle 4, dgrant_o again in cycles 5-8.
- daddr_i=0x80 (MEM_SIZE=32) → dgrant_o=1, mem_en_o=0; next cycle dvalid_o=1, drdata_o=0, err_o=1, fault_addr_o=0x80.
  - Repeat with iaddr_i=0x42 → ivalid_o with err_o=1, fault_addr_o=0x42.
- igrant_o in cycle 0, rst_i=0 in cycle 1 → ivalid_o stays 0; all outputs 0 after the edge. Normal operation resumes after rst_i=1.
